fu_issue_scheduler: RTL and testbench

- Sequences ready operations onto a pool of NUM_FU FunctionalUnit instances.
- Buffers operand-complete ops from the reservation stations in an in-order FIFO.
- Each cycle, dispatches the FIFO head to one available FU, chosen by round-robin.
- Sits between the reservation stations and the FU pool. Owns all FU write_enable lines; the op fields fan out to every FU.

---
 rtl/fu_issue_scheduler.sv | 170 +++++++++++++++++
 tb/tb_fu_issue_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
// fu_issue_scheduler
// In-order issue queue that feeds a pool of NUM_FU functional units.
// Ready ops from the reservation stations are buffered in a DEPTH-entry FIFO.
// Each cycle the head entry is dispatched to one available FU. The FU is
// picked round-robin, starting from rr_ptr.
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   flush             drop all queued ops at the next edge
//   enq_*             op payload and handshake from the reservation stations
//   fu_is_available   per-FU availability
//   fu_write_enable   per-FU issue strobe (one-hot or zero, combinational)
//   fu_*              head-entry fields, shared by every FU
//   occupancy         number of queued entries (registered)
module fu_issue_scheduler #(
  parameter int unsigned NUM_FU = 3,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PTR_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [3:0]        enq_ALUControl,
  input  logic              enq_ALUSrc,
  input  logic              enq_is_for_lsq,
  input  logic [31:0]       enq_imm,
  input  logic [31:0]       enq_rs1_value,
  input  logic [31:0]       enq_rs2_value,
  input  logic [5:0]        enq_tag,
  input  logic [5:0]        enq_rob_index,
  input  logic [NUM_FU-1:0] fu_is_available,
  output logic [NUM_FU-1:0] fu_write_enable,
  output logic [3:0]        fu_ALUControl,
  output logic              fu_ALUSrc,
  output logic              fu_is_for_lsq,
  output logic [31:0]       fu_imm,
  output logic [31:0]       fu_rs1_value,
  output logic [31:0]       fu_rs2_value,
  output logic [5:0]        fu_tag_to_output,
  output logic [5:0]        fu_rob_index,
  output logic [PTR_W:0]    occupancy
);

  localparam int unsigned RR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // One queued op
  typedef struct packed {
    logic [3:0]  alu_control;
    logic        alu_src;
    logic        is_for_lsq;
    logic [31:0] imm;
    logic [31:0] rs1_value;
    logic [31:0] rs2_value;
    logic [5:0]  tag;
    logic [5:0]  rob_index;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;
  logic [RR_W-1:0]   rr_ptr;

  entry_t            enq_entry;
  entry_t            head_entry;
  logic              do_enq;
  logic              dispatch;
  logic              cand_found;
  logic [RR_W-1:0]   cand_fu;
  logic [RR_W-1:0]   next_rr;

  // FU index base+off, wrapped modulo NUM_FU
  function automatic logic [RR_W-1:0] rr_idx(input logic [RR_W-1:0] base,
                                            input int unsigned     off);
    return RR_W'((32'(base) + off) % NUM_FU);
  endfunction

  assign enq_entry = '{
    alu_control: enq_ALUControl,
    alu_src:     enq_ALUSrc,
    is_for_lsq:  enq_is_for_lsq,
    imm:         enq_imm,
    rs1_value:   enq_rs1_value,
    rs2_value:   enq_rs2_value,
    tag:         enq_tag,
    rob_index:   enq_rob_index
  };

  // Full queue refuses new ops, even if the head leaves this same cycle
  assign enq_ready = (count != CNT_W'(DEPTH));
  assign do_enq    = enq_valid && enq_ready;

  // Round-robin search: the first available FU at or after rr_ptr
  always_comb begin
    cand_found = 1'b0;
    cand_fu    = '0;
    for (int k = 0; k < int'(NUM_FU); k++) begin
      if (!cand_found && fu_is_available[rr_idx(rr_ptr, 32'(k))]) begin
        cand_found = 1'b1;
        cand_fu    = rr_idx(rr_ptr, 32'(k));
      end
    end
  end

  // Issue is suppressed while reset is asserted, so nothing leaks out of a dying queue
  assign dispatch        = reset && (count != '0) && cand_found;
  assign fu_write_enable = dispatch ? (NUM_FU'(1) << cand_fu) : '0;
  assign next_rr         = rr_idx(cand_fu, 32'd1);

  // Head entry drives every FU's operand bus
  assign head_entry       = mem[head];
  assign fu_ALUControl    = head_entry.alu_control;
  assign fu_ALUSrc        = head_entry.alu_src;
  assign fu_is_for_lsq    = head_entry.is_for_lsq;
  assign fu_imm           = head_entry.imm;
  assign fu_rs1_value     = head_entry.rs1_value;
  assign fu_rs2_value     = head_entry.rs2_value;
  assign fu_tag_to_output = head_entry.tag;
  assign fu_rob_index     = head_entry.rob_index;
  assign occupancy        = count;

  // Queue pointers, storage and round-robin pointer
  always_ff @(posedge clk) begin
    if (!reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      rr_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      // A dispatch in the flush cycle is committed, so it still advances rr_ptr
      if (dispatch) begin
        rr_ptr <= next_rr;
      end
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_enq) begin
          mem[tail] <= enq_entry;
          tail      <= tail + PTR_W'(1);
        end
        if (dispatch) begin
          head <= head + PTR_W'(1);
        end
        case ({do_enq, dispatch})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // An issue strobe must only go to an available FU, and at most one strobe per cycle
  a_we_avail: assert property (@(posedge clk) disable iff (!reset)
    ((fu_write_enable & ~fu_is_available) == '0))
    else $fatal(1, "write_enable to unavailable FU");

  a_we_onehot: assert property (@(posedge clk) disable iff (!reset)
    $onehot0(fu_write_enable))
    else $fatal(1, "more than one write_enable asserted");

endmodule

// File: tb/tb_fu_issue_scheduler.sv
module tb_fu_issue_scheduler;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        enq_valid;
  logic        enq_ready;
  logic [3:0]  enq_ALUControl;
  logic        enq_ALUSrc;
  logic        enq_is_for_lsq;
  logic [31:0] enq_imm;
  logic [31:0] enq_rs1_value;
  logic [31:0] enq_rs2_value;
  logic [5:0]  enq_tag;
  logic [5:0]  enq_rob_index;
  logic [2:0]  fu_is_available;
  logic [2:0]  fu_write_enable;
  logic [3:0]  fu_ALUControl;
  logic        fu_ALUSrc;
  logic        fu_is_for_lsq;
  logic [31:0] fu_imm;
  logic [31:0] fu_rs1_value;
  logic [31:0] fu_rs2_value;
  logic [5:0]  fu_tag_to_output;
  logic [5:0]  fu_rob_index;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  fu_issue_scheduler #(.NUM_FU(3), .DEPTH(4), .PTR_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .enq_valid        (enq_valid),
    .enq_ready        (enq_ready),
    .enq_ALUControl   (enq_ALUControl),
    .enq_ALUSrc       (enq_ALUSrc),
    .enq_is_for_lsq   (enq_is_for_lsq),
    .enq_imm          (enq_imm),
    .enq_rs1_value    (enq_rs1_value),
    .enq_rs2_value    (enq_rs2_value),
    .enq_tag          (enq_tag),
    .enq_rob_index    (enq_rob_index),
    .fu_is_available  (fu_is_available),
    .fu_write_enable  (fu_write_enable),
    .fu_ALUControl    (fu_ALUControl),
    .fu_ALUSrc        (fu_ALUSrc),
    .fu_is_for_lsq    (fu_is_for_lsq),
    .fu_imm           (fu_imm),
    .fu_rs1_value     (fu_rs1_value),
    .fu_rs2_value     (fu_rs2_value),
    .fu_tag_to_output (fu_tag_to_output),
    .fu_rob_index     (fu_rob_index),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an ADD op whose fields derive from its ROB index
  task automatic enq_set(input logic [5:0] rob);
    enq_valid      = 1'b1;
    enq_ALUControl = 4'h0;
    enq_ALUSrc     = rob[0];
    enq_is_for_lsq = 1'b0;
    enq_imm        = 32'h1000 + 32'(rob);
    enq_rs1_value  = 32'hA000 + 32'(rob);
    enq_rs2_value  = 32'hB000 + 32'(rob);
    enq_tag        = rob;
    enq_rob_index  = rob;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; enq_valid = 1'b0;
    enq_ALUControl = '0; enq_ALUSrc = 1'b0; enq_is_for_lsq = 1'b0;
    enq_imm = '0; enq_rs1_value = '0; enq_rs2_value = '0;
    enq_tag = '0; enq_rob_index = '0; fu_is_available = 3'b000;

    // Reset then idle
    tick(); tick();
    reset = 1'b1;
    #1;
    check("rst_fu_imm", fu_imm, 32'h0);
    check("rst_fu_rob", fu_rob_index, 6'h0);
    check("rst_fu_tag", fu_tag_to_output, 6'h0);
    for (int c = 0; c < 5; c++) begin
      check("idle_ready", enq_ready, 1'b1);
      check("idle_occ", occupancy, 3'd0);
      check("idle_we", fu_write_enable, 3'b000);
      tick();
    end

    // Round-robin, all FUs available
    fu_is_available = 3'b111;
    enq_set(6'd1);
    #1;
    check("rr_we_empty", fu_write_enable, 3'b000);
    tick(); enq_set(6'd2); #1;
    check("rr1_we", fu_write_enable, 3'b001);
    check("rr1_rob", fu_rob_index, 6'd1);
    check("rr1_imm", fu_imm, 32'h1001);
    check("rr1_src", fu_ALUSrc, 1'b1);
    check("rr1_occ", occupancy, 3'd1);
    tick(); enq_set(6'd3); #1;
    check("rr2_we", fu_write_enable, 3'b010);
    check("rr2_rob", fu_rob_index, 6'd2);
    check("rr2_rs2", fu_rs2_value, 32'hB002);
    check("rr2_occ", occupancy, 3'd1);
    tick(); enq_set(6'd4); #1;
    check("rr3_we", fu_write_enable, 3'b100);
    check("rr3_rob", fu_rob_index, 6'd3);
    check("rr3_occ", occupancy, 3'd1);
    tick(); enq_valid = 1'b0; #1;
    check("rr4_we", fu_write_enable, 3'b001);
    check("rr4_rob", fu_rob_index, 6'd4);
    check("rr4_rs1", fu_rs1_value, 32'hA004);
    check("rr4_occ", occupancy, 3'd1);
    tick();
    check("rr_drain_occ", occupancy, 3'd0);
    check("rr_drain_we", fu_write_enable, 3'b000);

    // Skip busy FU from rr_ptr=0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    fu_is_available = 3'b110;
    enq_set(6'd7); enq_tag = 6'h15;
    tick(); enq_valid = 1'b0; #1;
    check("skip_we", fu_write_enable, 3'b010);
    check("skip_tag", fu_tag_to_output, 6'h15);
    tick();
    fu_is_available = 3'b111;
    enq_set(6'h16);
    tick(); enq_valid = 1'b0; #1;
    check("skip_next_rr_we", fu_write_enable, 3'b100);
    check("skip_next_rr_tag", fu_tag_to_output, 6'h16);
    tick();
    check("skip_occ", occupancy, 3'd0);

    // Full and backpressure (rr_ptr=0)
    fu_is_available = 3'b000;
    enq_set(6'd10); tick();
    enq_set(6'd11); tick();
    enq_set(6'd12); tick();
    enq_set(6'd13); tick();
    enq_set(6'd14); #1;
    check("full_occ", occupancy, 3'd4);
    check("full_ready", enq_ready, 1'b0);
    check("full_we", fu_write_enable, 3'b000);
    tick();
    check("full_hold_occ", occupancy, 3'd4);
    check("full_hold_rob", fu_rob_index, 6'd10);
    fu_is_available = 3'b001; #1;
    check("full_pop_we", fu_write_enable, 3'b001);
    check("full_pop_rob", fu_rob_index, 6'd10);
    tick();
    fu_is_available = 3'b000; #1;
    check("after_pop_occ", occupancy, 3'd3);
    check("after_pop_ready", enq_ready, 1'b1);
    check("after_pop_rob", fu_rob_index, 6'd11);
    check("after_pop_we", fu_write_enable, 3'b000);
    tick(); enq_valid = 1'b0; #1;
    check("refill_occ", occupancy, 3'd4);

    // Flush with concurrent enq (rr_ptr=1)
    fu_is_available = 3'b010; #1;
    check("preflush_we", fu_write_enable, 3'b010);
    check("preflush_rob", fu_rob_index, 6'd11);
    tick();
    fu_is_available = 3'b000;
    flush = 1'b1;
    enq_set(6'd20); #1;
    check("flush_pre_occ", occupancy, 3'd3);
    tick();
    flush = 1'b0; enq_valid = 1'b0;
    fu_is_available = 3'b111; #1;
    check("flush_occ", occupancy, 3'd0);
    check("flush_ready", enq_ready, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check("flush_no_dispatch", fu_write_enable, 3'b000);
      tick();
    end

    // Reset mid-stream (rr_ptr=2 before reset)
    fu_is_available = 3'b000;
    enq_set(6'd30); tick();
    enq_set(6'd31); tick();
    enq_valid = 1'b0; #1;
    check("mid_occ", occupancy, 3'd2);
    reset = 1'b0;
    fu_is_available = 3'b111; #1;
    check("mid_rst_we", fu_write_enable, 3'b000);
    tick();
    reset = 1'b1; #1;
    check("mid_post_occ", occupancy, 3'd0);
    check("mid_post_we", fu_write_enable, 3'b000);
    check("mid_post_ready", enq_ready, 1'b1);
    enq_set(6'd40);
    tick(); enq_valid = 1'b0; #1;
    check("mid_fu0_we", fu_write_enable, 3'b001);
    check("mid_fu0_rob", fu_rob_index, 6'd40);
    tick();
    check("mid_end_occ", occupancy, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
